// File: rtl/riscv_muldiv_issue_ctrl_pkg.sv
// riscv_instruction_properties: opcode/register types and M-extension helpers for the MDU issue controller
package riscv_instruction_properties;
  typedef enum logic [4:0] {
    INVALID_INSTR, ADD, SUB, ADDI, LW, SW, BEQ,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW
  } riscv_instr_name_t;
  typedef enum logic [4:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1, A0, A1, A2, A3, A4, A5,
    A6, A7, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, T3, T4, T5, T6
  } riscv_reg_t;
  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_WB} mdu_state_t;
  function automatic logic is_muldiv(riscv_instr_name_t op, int xlen);
    return (op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU}) ||
           (xlen == 64 && (op inside {MULW, DIVW, DIVUW, REMW, REMUW}));
  endfunction
  function automatic logic is_div(riscv_instr_name_t op);
    return op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
  endfunction
endpackage

// File: rtl/riscv_muldiv_issue_ctrl_scoreboard.sv
// riscv_reg_scoreboard: pending-write mask, set beats clear, x0 never marked
module riscv_reg_scoreboard
  import riscv_instruction_properties::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr_all,
  input  logic        i_set,
  input  riscv_reg_t  i_set_rd,
  input  logic        i_clr,
  input  riscv_reg_t  i_clr_rd,
  output logic [31:0] o_mask
);
  logic [31:0] r_mask, w_mask_nxt;
  // next mask: global clear, else clear the retired bit then set the issued one
  always_comb
    w_mask_nxt = i_clr_all ? 32'd0 :
                 ((r_mask & ~(i_clr ? 32'd1 << i_clr_rd : 32'd0)) |
                  (i_set ? 32'd1 << i_set_rd : 32'd0)) & ~32'd1;
  // mask register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mask <= '0;
    else r_mask <= w_mask_nxt;
  assign o_mask = r_mask;
endmodule

// File: rtl/riscv_muldiv_issue_ctrl.sv
// riscv_muldiv_issue_ctrl: single-op issue, latency timing and writeback handshake for the iterative MDU
module riscv_muldiv_issue_ctrl
  import riscv_instruction_properties::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  riscv_instr_name_t i_in_instr,
  input  riscv_reg_t        i_in_rd,
  output logic              o_unit_start,
  output riscv_instr_name_t o_unit_op,
  output logic              o_unit_kill,
  output logic              o_illegal,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output riscv_reg_t        o_wb_rd,
  output logic [31:0]       o_busy_mask
);
  localparam int MAXL = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);
  mdu_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_live, r_start, r_kill, r_illegal;
  riscv_instr_name_t r_op;
  riscv_reg_t r_rd;
  logic w_accept, w_legal, w_wb_fire;
  // handshakes and FSM next state; counter is loaded with latency-1 so WB lands LATENCY cycles after start
  always_comb begin
    o_in_ready  = r_live && !i_flush && (r_state == MDU_IDLE || (r_state == MDU_WB && i_wb_ready));
    o_wb_valid  = r_state == MDU_WB && !i_flush;
    w_accept    = i_in_valid && o_in_ready;
    w_legal     = is_muldiv(i_in_instr, XLEN);
    w_wb_fire   = o_wb_valid && i_wb_ready;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_flush) w_state_nxt = MDU_IDLE;
    else if (w_accept && w_legal) begin
      w_state_nxt = MDU_RUN;
      w_cnt_nxt   = is_div(i_in_instr) ? CW'(DIV_LATENCY - 1) : CW'(MUL_LATENCY - 1);
    end else if (w_accept || w_wb_fire) w_state_nxt = MDU_IDLE;
    else if (r_state == MDU_RUN) begin
      w_state_nxt = (r_cnt == '0) ? MDU_WB : MDU_RUN;
      w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
    end
  end
  // state, counter, one-cycle pulses and captured op/rd
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= MDU_IDLE;
      r_cnt     <= '0;
      r_live    <= 1'b0;
      r_start   <= 1'b0;
      r_kill    <= 1'b0;
      r_illegal <= 1'b0;
      r_op      <= INVALID_INSTR;
      r_rd      <= ZERO;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_live    <= 1'b1;
      r_start   <= w_accept && w_legal;
      r_kill    <= i_flush && r_state != MDU_IDLE;
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_op <= i_in_instr;
        r_rd <= i_in_rd;
      end
    end
  riscv_reg_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr_all(i_flush),
    .i_set    (w_accept && w_legal),
    .i_set_rd (i_in_rd),
    .i_clr    (w_wb_fire),
    .i_clr_rd (r_rd),
    .o_mask   (o_busy_mask)
  );
  assign o_unit_start = r_start;
  assign o_unit_op    = r_op;
  assign o_unit_kill  = r_kill;
  assign o_illegal    = r_illegal;
  assign o_wb_rd      = r_rd;
endmodule

// File: tb/tb_riscv_muldiv_issue_ctrl.sv
// tb_riscv_muldiv_issue_ctrl: directed stimulus with a writeback scoreboard for the MDU issue controller
module tb_riscv_muldiv_issue_ctrl;
  import riscv_instruction_properties::*;
  typedef struct {
    riscv_reg_t rd;
    riscv_instr_name_t op;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, wb_ready;
  riscv_instr_name_t in_instr;
  riscv_reg_t in_rd;
  logic in_ready, unit_start, unit_kill, illegal, wb_valid;
  riscv_instr_name_t unit_op;
  riscv_reg_t wb_rd;
  logic [31:0] busy;
  logic in_ready64, start64, kill64, illegal64, wb_valid64;
  riscv_instr_name_t op64;
  riscv_reg_t wb_rd64;
  logic [31:0] busy64;
  exp_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscv_muldiv_issue_ctrl #(.XLEN(32), .MUL_LATENCY(4), .DIV_LATENCY(33)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_rd(in_rd), .o_unit_start(unit_start), .o_unit_op(unit_op),
    .o_unit_kill(unit_kill), .o_illegal(illegal), .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
    .o_wb_rd(wb_rd), .o_busy_mask(busy)
  );
  riscv_muldiv_issue_ctrl #(.XLEN(64), .MUL_LATENCY(4), .DIV_LATENCY(33)) dut64 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready64),
    .i_in_instr(in_instr), .i_in_rd(in_rd), .o_unit_start(start64), .o_unit_op(op64),
    .o_unit_kill(kill64), .o_illegal(illegal64), .o_wb_valid(wb_valid64), .i_wb_ready(wb_ready),
    .o_wb_rd(wb_rd64), .o_busy_mask(busy64)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic offer(input riscv_instr_name_t op, input logic [4:0] rd, input logic expect_wb);
    exp_t e;
    in_valid = 1'b1;
    in_instr = op;
    in_rd = riscv_reg_t'(rd);
    if (expect_wb) begin
      e.rd = riscv_reg_t'(rd);
      e.op = op;
      q.push_back(e);
    end
  endtask

  // writeback monitor: every handshake must match the oldest expected result
  always @(negedge clk)
    if (rst_n && wb_valid && wb_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected at %0t: got rd=%0d with no expected result", $time, wb_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_op", 32'(unit_op), 32'(e.op));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    in_instr = INVALID_INSTR; in_rd = ZERO;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_unit_op", 32'(unit_op), 32'(INVALID_INSTR));
    chk("rst_start", 32'(unit_start), 0);
    cyc(); rst_n = 1'b1;
    cyc(); @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);
    // MUL x5, latency 4
    cyc(); wb_ready = 1'b1; offer(MUL, 5, 1'b1); @(negedge clk);
    chk("t1_in_ready", 32'(in_ready), 1);
    for (int k = 1; k <= 6; k++) begin
      cyc(); @(negedge clk);
      chk("t1_start", 32'(unit_start), 32'(k == 1));
      chk("t1_wb_valid", 32'(wb_valid), 32'(k == 5));
      chk("t1_busy5", 32'(busy[5]), 32'(k <= 5));
      if (k == 1) chk("t1_unit_op", 32'(unit_op), 32'(MUL));
    end
    // DIV x7 with wb_ready held low until cycle 40
    cyc(); wb_ready = 1'b0; offer(DIV, 7, 1'b1); @(negedge clk);
    for (int k = 1; k <= 41; k++) begin
      cyc(); wb_ready = (k >= 40); @(negedge clk);
      chk("t2_wb_valid", 32'(wb_valid), 32'(k >= 34 && k <= 40));
      chk("t2_busy7", 32'(busy[7]), 32'(k <= 40));
      chk("t2_in_ready", 32'(in_ready), 32'(k >= 40));
      if (k >= 34 && k <= 40) chk("t2_wb_rd", 32'(wb_rd), 7);
    end
    // REM x3 then MUL x3 accepted during the writeback handshake
    cyc(); wb_ready = 1'b1; offer(REM, 3, 1'b1); @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      cyc(); if (k == 34) offer(MUL, 3, 1'b1); @(negedge clk);
      chk("t3_busy3", 32'(busy[3]), 32'(k <= 39));
      chk("t3_start", 32'(unit_start), 32'(k == 1 || k == 35));
      chk("t3_wb_valid", 32'(wb_valid), 32'(k == 34 || k == 39));
      if (k == 34) chk("t3_in_ready", 32'(in_ready), 1);
      if (k == 35) chk("t3_unit_op", 32'(unit_op), 32'(MUL));
    end
    // ADD is not an M op
    cyc(); offer(ADD, 4, 1'b0); @(negedge clk);
    chk("t4_illegal_same", 32'(illegal), 0);
    for (int k = 1; k <= 2; k++) begin
      cyc(); @(negedge clk);
      chk("t4_illegal", 32'(illegal), 32'(k == 1));
      chk("t4_start", 32'(unit_start), 0);
      chk("t4_busy", busy, 0);
      chk("t4_in_ready", 32'(in_ready), 1);
    end
    // MULW: illegal for XLEN=32, launched for XLEN=64
    cyc(); offer(MULW, 6, 1'b0); @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      cyc(); @(negedge clk);
      chk("t4w_illegal32", 32'(illegal), 32'(k == 1));
      chk("t4w_start32", 32'(unit_start), 0);
      chk("t4w_busy32", busy, 0);
      chk("t4w_start64", 32'(start64), 32'(k == 1));
      chk("t4w_illegal64", 32'(illegal64), 0);
      chk("t4w_wb_valid64", 32'(wb_valid64), 32'(k == 5));
      chk("t4w_busy64", 32'(busy64[6]), 32'(k <= 5));
      if (k == 5) chk("t4w_wb_rd64", 32'(wb_rd64), 6);
    end
    // flush mid-RUN of DIVU x9, new op accepted right after, then flush while idle
    cyc(); offer(DIVU, 9, 1'b0); @(negedge clk);
    for (int k = 1; k <= 19; k++) begin
      cyc();
      if (k == 10) begin flush = 1'b1; offer(MUL, 2, 1'b0); end
      if (k == 11) offer(MUL, 8, 1'b1);
      if (k == 18) flush = 1'b1;
      @(negedge clk);
      chk("t5_kill", 32'(unit_kill), 32'(k == 11));
      chk("t5_wb_valid", 32'(wb_valid), 32'(k == 16));
      chk("t5_start", 32'(unit_start), 32'(k == 1 || k == 12));
      chk("t5_busy", busy, k <= 10 ? 32'h200 : (k >= 12 && k <= 16) ? 32'h100 : 32'h0);
      if (k == 10) chk("t5_in_ready_flush", 32'(in_ready), 0);
      if (k == 11) chk("t5_in_ready_after", 32'(in_ready), 1);
    end
    // rd = x0: no busy bit, result still written back
    cyc(); offer(MUL, 0, 1'b1); @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      cyc(); @(negedge clk);
      chk("t6_busy_x0", busy, 0);
      chk("t6_wb_valid_x0", 32'(wb_valid), 32'(k == 5));
    end
    // asynchronous reset mid-RUN of DIV x10
    cyc(); offer(DIV, 10, 1'b0); @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      cyc(); @(negedge clk);
      chk("t6_busy10", busy, 32'h400);
      chk("t6_start10", 32'(unit_start), 32'(k == 1));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wb_valid", 32'(wb_valid), 0);
    chk("t6_rst_unit_op", 32'(unit_op), 32'(INVALID_INSTR));
    chk("t6_rst_wb_rd", 32'(wb_rd), 0);
    cyc(); rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(); @(negedge clk);
      chk("t6_post_in_ready", 32'(in_ready), 1);
      chk("t6_post_wb_valid", 32'(wb_valid), 0);
      chk("t6_post_busy", busy, 0);
    end
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
